// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-master arbiter in front of the single data RAM (1-cycle read latency).
//   Master 0 is the core load/store path, master 1 is the JTAG debug memory
//   port. At most one access is granted per cycle; the read response is routed
//   back to the master that issued it one cycle later.
//
//   Optional feature: define MEM_ARB_RR_EN to resolve contention in ARB
//   round-robin (last-winner register) instead of fixed M0 priority with the
//   STARVE_MAX escape.
//
// Parameters
//   DW          data width
//   AW          address width
//   STARVE_MAX  consecutive losing cycles before M1 is forced to win (1..15)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   m0_req/wen/addr/wdata           core request (wen==0 -> read)
//   m0_gnt/rvalid/rdata             core grant and read response
//   m1_req/wen/addr/wdata/lock      JTAG request; lock keeps the bus after grant
//   m1_gnt/rvalid/rdata             JTAG grant and read response
//   ram_wen/w_addr/w_data           RAM write port
//   ram_ren/r_addr, ram_r_data      RAM read port (data valid 1 cycle after ren)
//   core_stall                      core is requesting but not granted
module ram_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [3:0]    m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_ren,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data,
  output logic          core_stall
);

  typedef enum logic [0:0] {ARB, LOCK1} state_t;

  state_t          state, state_nxt;
  logic            gnt0_p0, gnt1_p0;
  logic            win1_p0;
  logic [3:0]      wen_p0;
  logic [AW-1:0]   addr_p0;
  logic [DW-1:0]   wdata_p0;
  logic            granted_p0;
  logic            rd_p0;
  logic            vld_p1;
  logic            own_p1;

`ifdef MEM_ARB_RR_EN
  logic            last_win;

  // Round-robin: the master that did not win last time takes the contended cycle.
  assign win1_p0 = ~last_win;

  always_ff @(posedge clk) begin
    if (rst)          last_win <= 1'b0;
    else if (gnt0_p0) last_win <= 1'b0;
    else if (gnt1_p0) last_win <= 1'b1;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]      starve_cnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  assign win1_p0 = (starve_cnt == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst)                     starve_cnt <= 4'd0;
    else if (!m1_req || gnt1_p0) starve_cnt <= 4'd0;
    else                         starve_cnt <= sat_inc(starve_cnt);
  end
`endif

  // ---- p0: grant decision and RAM request drive ----
  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Grants are forced low during reset so every output sits at its reset value.
  always_comb begin
    state_nxt = state;
    gnt0_p0   = 1'b0;
    gnt1_p0   = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (m0_req && m1_req) begin
            gnt1_p0 = win1_p0;
            gnt0_p0 = ~win1_p0;
          end else begin
            gnt0_p0 = m0_req;
            gnt1_p0 = m1_req;
          end
          if (gnt1_p0 && m1_lock) state_nxt = LOCK1;
        end
        LOCK1: begin
          gnt1_p0 = m1_req;
          if (!(m1_req && m1_lock)) state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  assign wen_p0     = gnt1_p0 ? m1_wen   : m0_wen;
  assign addr_p0    = gnt1_p0 ? m1_addr  : m0_addr;
  assign wdata_p0   = gnt1_p0 ? m1_wdata : m0_wdata;
  assign granted_p0 = gnt0_p0 | gnt1_p0;
  assign rd_p0      = granted_p0 && (wen_p0 == 4'd0);

  assign m0_gnt     = gnt0_p0;
  assign m1_gnt     = gnt1_p0;
  assign core_stall = m0_req & ~gnt0_p0 & ~rst;

  assign ram_wen    = granted_p0 ? wen_p0 : 4'd0;
  assign ram_ren    = rd_p0;
  assign ram_w_addr = addr_p0;
  assign ram_r_addr = addr_p0;
  assign ram_w_data = wdata_p0;

  // ---- p1: read response routed to the owner of the previous cycle's read ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      own_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_p0;
      own_p1 <= gnt1_p0;
    end
  end

  assign m0_rvalid = vld_p1 & ~own_p1 & ~rst;
  assign m1_rvalid = vld_p1 &  own_p1 & ~rst;
  assign m0_rdata  = m0_rvalid ? ram_r_data : '0;
  assign m1_rdata  = m1_rvalid ? ram_r_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by randomized traffic,
// compared every cycle against a behavioural model of the arbitration rules
// and a shadow copy of memory contents.
module tb_ram_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m1_lock;
  logic [3:0]    m0_wen, m1_wen;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
  logic          ram_ren;
  logic          core_stall;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  // RAM contents: unwritten words hold a fixed pattern, 0x10 holds 0xDEADBEEF.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic [31:0] ram_mem [256];
  bit          ram_wr  [256];

  function automatic logic [31:0] ram_cur(input logic [7:0] a);
    return ram_wr[a] ? ram_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (ram_ren) ram_r_data <= ram_cur(ram_r_addr[7:0]);
    if (ram_wen != 4'd0) begin
      ram_mem[ram_w_addr[7:0]] <= merge(ram_cur(ram_w_addr[7:0]), ram_w_data, ram_wen);
      ram_wr[ram_w_addr[7:0]]  <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] shadow [256];
  bit          md_lock;
  int          md_starve;
  bit          md_last;
  bit          md_pend;
  bit          md_own;
  logic [31:0] md_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic q0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic q1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk);
    bit          e0, e1, win1, rv0, rv1, erd;
    logic [3:0]  ew, ewen;
    logic [31:0] ea, ed;
    @(negedge clk);
    rst = r; m0_req = q0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_wen = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
    #2;
    e0 = 1'b0; e1 = 1'b0;
    if (!r) begin
      if (md_lock) e1 = q1;
      else if (q0 && q1) begin
`ifdef MEM_ARB_RR_EN
        win1 = !md_last;
`else
        win1 = (md_starve == SMAX);
`endif
        e1 = win1; e0 = !win1;
      end else begin
        e0 = q0; e1 = q1;
      end
    end
    ew   = e1 ? w1 : w0;
    ea   = e1 ? a1 : a0;
    ed   = e1 ? d1 : d0;
    ewen = (e0 || e1) ? ew : 4'd0;
    erd  = (e0 || e1) && (ew == 4'd0);
    rv0  = !r && md_pend && !md_own;
    rv1  = !r && md_pend && md_own;

    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    chk("core_stall", 32'(core_stall), 32'(q0 && !e0 && !r));
    chk("ram_wen", 32'(ram_wen), 32'(ewen));
    chk("ram_ren", 32'(ram_ren), 32'(erd));
    if (erd) chk("ram_r_addr", ram_r_addr, ea);
    if (ewen != 4'd0) begin
      chk("ram_w_addr", ram_w_addr, ea);
      chk("ram_w_data", ram_w_data, ed);
    end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
    chk("m0_rdata", m0_rdata, rv0 ? md_data : 32'h0);
    chk("m1_rdata", m1_rdata, rv1 ? md_data : 32'h0);

    if (r) begin
      md_lock = 0; md_starve = 0; md_last = 0; md_pend = 0; md_own = 0;
    end else begin
      md_pend = erd;
      md_own  = e1;
      if (erd) md_data = shadow[ea[7:0]];
      if (ewen != 4'd0) shadow[ea[7:0]] = merge(shadow[ea[7:0]], ed, ewen);
      md_lock   = md_lock ? (q1 && lk) : (e1 && lk);
      md_starve = (!q1 || e1) ? 0 : ((md_starve + 1 > SMAX) ? SMAX : md_starve + 1);
      if (e0) md_last = 0;
      else if (e1) md_last = 1;
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int m1_wins;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    md_lock = 0; md_starve = 0; md_last = 0; md_pend = 0; md_own = 0; md_data = '0;
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    m0_wen = '0; m1_wen = '0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;

    idle(1'b1);
    idle(1'b1);

    // M0 read of 0x10 alone
    step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    idle(1'b0);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);

    // Both masters reading continuously
    m1_wins = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      if (m1_gnt) m1_wins++;
    end
`ifndef MEM_ARB_RR_EN
    chk("t2_m1_wins", 32'(m1_wins), 32'd2);
`endif
    idle(1'b0);

    // M1 locked writes while M0 keeps requesting
    step(1'b0, 1'b0, 4'h0, 32'h14, 32'h0, 1'b1, 4'hF, 32'h20, 32'hCAFE0000, 1'b1);
    step(1'b0, 1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 4'hF, 32'h20, 32'hCAFE0001, 1'b1);
    step(1'b0, 1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 4'hF, 32'h20, 32'hCAFE0002, 1'b1);
    step(1'b0, 1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 4'hF, 32'h20, 32'hCAFE0003, 1'b0);
    step(1'b0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("t3_m0_gnt", 32'(m0_gnt), 32'd1);
    idle(1'b0);
    chk("t3_rdata", m0_rdata, 32'hCAFE0003);

    // Alternating single-master reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        step(1'b0, 1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      else
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'(i * 4 + 64), 32'h0, 1'b0);
    end
    idle(1'b0);

    // Reset right after a granted M1 read drops the response
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1);
    idle(1'b1);
    chk("t5_m1_rvalid", 32'(m1_rvalid), 32'd0);
    idle(1'b0);
    step(1'b0, 1'b1, 4'h0, 32'h4, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, q0, q1, lk;
      logic [3:0] w0, w1;
      r  = ($urandom_range(0, 99) < 2);
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      lk = ($urandom_range(0, 3) == 0);
      w0 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      w1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(r, q0, w0, 32'($urandom_range(0, 255)), $urandom,
              q1, w1, 32'($urandom_range(0, 255)), $urandom, lk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
